// File: rtl/pic_ctrl_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pic_ctrl_resp_pkg
// Brief    : PIC register map offsets, merge masks and address decode helper.
// Revision : 1.0 - initial release
// ============================================================================
package pic_ctrl_resp_pkg;

  localparam logic [31:0] PIC_MEIPL_OFF      = 32'h0000_0000;
  localparam logic [31:0] PIC_MEIP_OFF       = 32'h0000_1000;
  localparam logic [31:0] PIC_MEIE_OFF       = 32'h0000_2000;
  localparam logic [31:0] PIC_MEIGWCTRL_OFF  = 32'h0000_4000;
  localparam logic [31:0] PIC_MEIGWCLR_OFF   = 32'h0000_5000;

  localparam logic [31:0] PIC_MEIPL_MASK     = 32'h0000_000F;
  localparam logic [31:0] PIC_MEIP_MASK      = 32'h0000_0000;
  localparam logic [31:0] PIC_MEIE_MASK      = 32'h0000_0001;
  localparam logic [31:0] PIC_MEIGWCTRL_MASK = 32'h0000_0003;
  localparam logic [31:0] PIC_MEIGWCLR_MASK  = 32'h0000_0000;

  localparam int PIC_IDX_W = 10;

  typedef enum logic [2:0] {
    PIC_REG_NONE      = 3'd0,
    PIC_REG_MEIPL     = 3'd1,
    PIC_REG_MEIP      = 3'd2,
    PIC_REG_MEIE      = 3'd3,
    PIC_REG_MEIGWCTRL = 3'd4,
    PIC_REG_MEIGWCLR  = 3'd5
  } pic_reg_e;

  typedef enum logic {
    PIC_GW_LEVEL = 1'b0,
    PIC_GW_EDGE  = 1'b1
  } pic_gw_type_e;

  typedef struct packed {
    pic_reg_e               sel;
    logic [PIC_IDX_W-1:0]   idx;
  } pic_dec_t;

  // Offset must already be trimmed to the decoded bits with [1:0] cleared.
  function automatic pic_dec_t pic_decode(input logic [31:0] off);
    pic_dec_t d;
    d.sel = PIC_REG_NONE;
    d.idx = off[11:2];
    if (off == PIC_MEIP_OFF)                                d.sel = PIC_REG_MEIP;
    else if (off[31:12] == PIC_MEIPL_OFF[31:12])            d.sel = PIC_REG_MEIPL;
    else if (off[31:12] == PIC_MEIE_OFF[31:12])             d.sel = PIC_REG_MEIE;
    else if (off[31:12] == PIC_MEIGWCTRL_OFF[31:12])        d.sel = PIC_REG_MEIGWCTRL;
    else if (off[31:12] == PIC_MEIGWCLR_OFF[31:12])         d.sel = PIC_REG_MEIGWCLR;
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pic_ctrl_resp_gateway.sv
`default_nettype none
// ============================================================================
// Module   : pic_gateway
// Brief    : Per-source interrupt gateway: polarity, level/edge, edge latch.
// Revision : 1.0 - initial release
// ============================================================================
module pic_gateway
  import pic_ctrl_resp_pkg::*;
(
  input  logic clk,
  input  logic rst_l,
  input  logic req_i,
  input  logic polarity_i,
  input  logic type_i,
  input  logic clr_i,
  output logic pending_o
);

  logic w_x;
  logic x_q, x_d;
  logic latch_q, latch_d;
  logic w_edge_mode;

  assign w_edge_mode = (type_i == PIC_GW_EDGE);
  assign w_x         = req_i ^ polarity_i;

  // Set wins over a coincident clear; level mode keeps the latch empty.
  always_comb begin
    x_d     = w_x;
    latch_d = 1'b0;
    if (w_edge_mode) latch_d = (w_x & ~x_q) | (latch_q & ~clr_i);
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      x_q     <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      latch_q <= latch_d;
    end
  end

  assign pending_o = w_edge_mode ? latch_q : x_q;

endmodule
`default_nettype wire

// File: rtl/pic_ctrl_resp.sv
`default_nettype none
// ============================================================================
// Module   : pic_ctrl_resp
// Brief    : PIC register file responder for the LSU port plus claim arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module pic_ctrl_resp
  import pic_ctrl_resp_pkg::*;
#(
  parameter int TOTAL_INT = 8,
  parameter int PIC_BITS  = 15,
  parameter int PL_BITS   = 4
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 picm_rden,
  input  logic                 picm_mken,
  input  logic                 picm_wren,
  input  logic [31:0]          picm_addr,
  input  logic [31:0]          picm_wr_data,
  output logic [31:0]          picm_rd_data,
  input  logic [TOTAL_INT:0]   extintsrc_req,
  output logic                 mexintpend,
  output logic [7:0]           claimid,
  output logic [PL_BITS-1:0]   pl
);

  localparam logic [31:0] ADDR_MASK =
    (PIC_BITS >= 32) ? 32'hFFFF_FFFF : ((32'd1 << PIC_BITS) - 32'd1);

  logic [31:0]                      w_off;
  pic_dec_t                         w_dec;
  logic [31:0]                      w_rd_val, w_mask_val;
  logic [TOTAL_INT:1]               w_gw_clr, w_pending;

  logic [TOTAL_INT:1][PL_BITS-1:0]  meipl_q, meipl_d;
  logic [TOTAL_INT:1]               meie_q, meie_d;
  logic [TOTAL_INT:1]               gw_pol_q, gw_pol_d;
  logic [TOTAL_INT:1]               gw_type_q, gw_type_d;
  logic [31:0]                      rd_data_q, rd_data_d;
  logic [7:0]                       claimid_q, claimid_d;
  logic [PL_BITS-1:0]               pl_q, pl_d;
  logic                             mexintpend_q, mexintpend_d;

  logic w_unused;
  assign w_unused = ^{extintsrc_req[0], picm_wr_data[31:PL_BITS]};

  assign w_off = picm_addr & ADDR_MASK & 32'hFFFF_FFFC;
  assign w_dec = pic_decode(w_off);

  // Register access: source 0 and ids above TOTAL_INT never match the loop.
  always_comb begin
    meipl_d    = meipl_q;
    meie_d     = meie_q;
    gw_pol_d   = gw_pol_q;
    gw_type_d  = gw_type_q;
    w_gw_clr   = '0;
    w_rd_val   = '0;
    w_mask_val = '0;
    if (w_dec.sel == PIC_REG_MEIP) begin
      w_rd_val   = 32'({w_pending, 1'b0});
      w_mask_val = PIC_MEIP_MASK;
    end
    for (int i = 1; i <= TOTAL_INT; i++) begin
      if (w_dec.idx == PIC_IDX_W'(i)) begin
        case (w_dec.sel)
          PIC_REG_MEIPL: begin
            w_rd_val   = 32'(meipl_q[i]);
            w_mask_val = PIC_MEIPL_MASK;
            if (picm_wren) meipl_d[i] = picm_wr_data[PL_BITS-1:0];
          end
          PIC_REG_MEIE: begin
            w_rd_val   = 32'(meie_q[i]);
            w_mask_val = PIC_MEIE_MASK;
            if (picm_wren) meie_d[i] = picm_wr_data[0];
          end
          PIC_REG_MEIGWCTRL: begin
            w_rd_val   = 32'({gw_type_q[i], gw_pol_q[i]});
            w_mask_val = PIC_MEIGWCTRL_MASK;
            if (picm_wren) begin
              gw_pol_d[i]  = picm_wr_data[0];
              gw_type_d[i] = picm_wr_data[1];
            end
          end
          PIC_REG_MEIGWCLR: begin
            w_mask_val  = PIC_MEIGWCLR_MASK;
            w_gw_clr[i] = picm_wren;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (picm_rden)      rd_data_d = w_rd_val;
    else if (picm_mken) rd_data_d = w_mask_val;
  end

  // Strict greater-than keeps the lowest id on equal priority.
  always_comb begin
    claimid_d = '0;
    pl_d      = '0;
    for (int i = 1; i <= TOTAL_INT; i++) begin
      if (w_pending[i] && meie_q[i] && (meipl_q[i] > pl_d)) begin
        claimid_d = 8'(i);
        pl_d      = meipl_q[i];
      end
    end
    mexintpend_d = (claimid_d != 8'd0);
  end

  for (genvar g = 1; g <= TOTAL_INT; g++) begin : g_gw
    pic_gateway u_gw (
      .clk        (clk),
      .rst_l      (rst_l),
      .req_i      (extintsrc_req[g]),
      .polarity_i (gw_pol_q[g]),
      .type_i     (gw_type_q[g]),
      .clr_i      (w_gw_clr[g]),
      .pending_o  (w_pending[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      meipl_q      <= '0;
      meie_q       <= '0;
      gw_pol_q     <= '0;
      gw_type_q    <= '0;
      rd_data_q    <= '0;
      claimid_q    <= '0;
      pl_q         <= '0;
      mexintpend_q <= 1'b0;
    end else begin
      meipl_q      <= meipl_d;
      meie_q       <= meie_d;
      gw_pol_q     <= gw_pol_d;
      gw_type_q    <= gw_type_d;
      rd_data_q    <= rd_data_d;
      claimid_q    <= claimid_d;
      pl_q         <= pl_d;
      mexintpend_q <= mexintpend_d;
    end
  end

  assign picm_rd_data = rd_data_q;
  assign claimid      = claimid_q;
  assign pl           = pl_q;
  assign mexintpend   = mexintpend_q;

endmodule
`default_nettype wire

// File: tb/tb_pic_ctrl_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_pic_ctrl_resp
// Brief    : Self-checking bench for pic_ctrl_resp (vector table + sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pic_ctrl_resp;

  localparam int TOTAL_INT = 8;
  localparam int PIC_BITS  = 15;
  localparam int PL_BITS   = 4;

  logic                clk = 1'b0;
  logic                rst_l = 1'b0;
  logic                picm_rden = 1'b0;
  logic                picm_mken = 1'b0;
  logic                picm_wren = 1'b0;
  logic [31:0]         picm_addr = '0;
  logic [31:0]         picm_wr_data = '0;
  logic [31:0]         picm_rd_data;
  logic [TOTAL_INT:0]  extintsrc_req = '0;
  logic                mexintpend;
  logic [7:0]          claimid;
  logic [PL_BITS-1:0]  pl;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] sb_exp[$];
  string       sb_name[$];

  typedef struct {
    logic        rden;
    logic        mken;
    logic        wren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  pic_ctrl_resp #(
    .TOTAL_INT (TOTAL_INT),
    .PIC_BITS  (PIC_BITS),
    .PL_BITS   (PL_BITS)
  ) dut (
    .clk           (clk),
    .rst_l         (rst_l),
    .picm_rden     (picm_rden),
    .picm_mken     (picm_mken),
    .picm_wren     (picm_wren),
    .picm_addr     (picm_addr),
    .picm_wr_data  (picm_wr_data),
    .picm_rd_data  (picm_rd_data),
    .extintsrc_req (extintsrc_req),
    .mexintpend    (mexintpend),
    .claimid       (claimid),
    .pl            (pl)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic rden, input logic mken, input logic wren,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic chk, input logic [31:0] exp, input string name);
    string       nm;
    logic [31:0] ex;
    picm_rden    = rden;
    picm_mken    = mken;
    picm_wren    = wren;
    picm_addr    = addr;
    picm_wr_data = wdata;
    if (chk) begin
      sb_exp.push_back(exp);
      sb_name.push_back(name);
    end
    tick();
    picm_rden = 1'b0;
    picm_mken = 1'b0;
    picm_wren = 1'b0;
    if (chk) begin
      nm = sb_name.pop_front();
      ex = sb_exp.pop_front();
      check(nm, picm_rd_data, ex);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    req(1'b0, 1'b0, 1'b1, addr, data, 1'b0, 32'h0, "wr");
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    req(1'b1, 1'b0, 1'b0, addr, 32'h0, 1'b1, exp, name);
  endtask

  task automatic check_claim(input string name, input logic [7:0] id,
                             input logic [PL_BITS-1:0] p, input logic pend);
    check({name, "_claimid"}, 32'(claimid), 32'(id));
    check({name, "_pl"}, 32'(pl), 32'(p));
    check({name, "_mexintpend"}, 32'(mexintpend), 32'(pend));
  endtask

  function automatic vec_t mkv(input logic rden, input logic mken, input logic wren,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic chk, input logic [31:0] exp, input string name);
    vec_t v;
    v.rden = rden; v.mken = mken; v.wren = wren;
    v.addr = addr; v.wdata = wdata; v.chk = chk; v.exp = exp; v.name = name;
    return v;
  endfunction

  initial begin
    // Reset
    rst_l = 1'b0;
    tick();
    tick();
    check("reset_rd_data", picm_rd_data, 32'h0);
    check_claim("reset", 8'd0, '0, 1'b0);
    rst_l = 1'b1;
    tick();

    // Register-file vectors
    vecs.push_back(mkv(0, 0, 1, 32'h0000_000C, 32'h0000_000A, 0, 32'h0, "wr_meipl3"));
    vecs.push_back(mkv(1, 0, 0, 32'h0000_000C, 32'h0,         1, 32'h0000_000A, "rd_meipl3"));
    vecs.push_back(mkv(0, 1, 0, 32'h0000_000C, 32'h0,         1, 32'h0000_000F, "mk_meipl3"));
    vecs.push_back(mkv(1, 0, 0, 32'h0000_0000, 32'h0,         1, 32'h0, "rd_meipl0"));
    vecs.push_back(mkv(0, 1, 0, 32'h0000_0000, 32'h0,         1, 32'h0, "mk_meipl0"));
    vecs.push_back(mkv(1, 1, 0, 32'h0000_000C, 32'h0,         1, 32'h0000_000A, "rd_wins_mk"));
    vecs.push_back(mkv(0, 0, 1, 32'h0000_000C, 32'hFFFF_FFF5, 0, 32'h0, "wr_meipl3_wide"));
    vecs.push_back(mkv(1, 0, 0, 32'hF000_800C, 32'h0,         1, 32'h0000_0005, "rd_hi_addr"));
    vecs.push_back(mkv(0, 1, 0, 32'h0000_1000, 32'h0,         1, 32'h0, "mk_meip"));
    vecs.push_back(mkv(1, 0, 0, 32'h0000_1000, 32'h0,         1, 32'h0, "rd_meip_idle"));
    vecs.push_back(mkv(0, 1, 0, 32'h0000_2008, 32'h0,         1, 32'h0000_0001, "mk_meie2"));
    vecs.push_back(mkv(0, 1, 0, 32'h0000_4008, 32'h0,         1, 32'h0000_0003, "mk_gwctrl2"));
    vecs.push_back(mkv(0, 1, 0, 32'h0000_5008, 32'h0,         1, 32'h0, "mk_gwclr2"));
    vecs.push_back(mkv(1, 0, 0, 32'h0000_5008, 32'h0,         1, 32'h0, "rd_gwclr2"));
    vecs.push_back(mkv(0, 0, 1, 32'h0000_2024, 32'h0000_0001, 0, 32'h0, "wr_meie9"));
    vecs.push_back(mkv(1, 0, 0, 32'h0000_2024, 32'h0,         1, 32'h0, "rd_meie9"));
    vecs.push_back(mkv(0, 1, 0, 32'h0000_0024, 32'h0,         1, 32'h0, "mk_meipl9"));
    vecs.push_back(mkv(0, 1, 0, 32'h0000_0020, 32'h0,         1, 32'h0000_000F, "mk_meipl8"));
    vecs.push_back(mkv(0, 0, 1, 32'h0000_401C, 32'h0000_0003, 0, 32'h0, "wr_gwctrl7"));
    vecs.push_back(mkv(1, 0, 0, 32'h0000_401C, 32'h0,         1, 32'h0000_0003, "rd_gwctrl7"));
    vecs.push_back(mkv(0, 0, 1, 32'h0000_401C, 32'h0,         0, 32'h0, "wr_gwctrl7_0"));
    vecs.push_back(mkv(1, 0, 0, 32'h0000_401C, 32'h0,         1, 32'h0, "rd_gwctrl7_0"));
    vecs.push_back(mkv(1, 0, 0, 32'h0000_3008, 32'h0,         1, 32'h0, "rd_unmapped"));
    vecs.push_back(mkv(0, 1, 0, 32'h0000_3008, 32'h0,         1, 32'h0, "mk_unmapped"));
    vecs.push_back(mkv(1, 0, 1, 32'h0000_2008, 32'h0000_0001, 1, 32'h0, "rdwr_meie2_old"));
    vecs.push_back(mkv(1, 0, 0, 32'h0000_2008, 32'h0,         1, 32'h0000_0001, "rd_meie2_new"));

    for (int i = 0; i < vecs.size(); i++)
      req(vecs[i].rden, vecs[i].mken, vecs[i].wren, vecs[i].addr,
          vecs[i].wdata, vecs[i].chk, vecs[i].exp, vecs[i].name);

    // Read data holds with no new request
    tick();
    tick();
    check("rd_hold", picm_rd_data, 32'h0000_0001);

    // Edge gateway on source 5
    wr(32'h0000_4014, 32'h0000_0002);
    extintsrc_req[5] = 1'b1;
    tick();
    extintsrc_req[5] = 1'b0;
    rd(32'h0000_1000, 32'h0000_0020, "meip_edge_set");
    rd(32'h0000_1000, 32'h0000_0020, "meip_edge_hold");
    extintsrc_req[5] = 1'b1;
    wr(32'h0000_5014, 32'h0);
    extintsrc_req[5] = 1'b0;
    rd(32'h0000_1000, 32'h0000_0020, "meip_set_beats_clr");
    wr(32'h0000_5014, 32'h0);
    rd(32'h0000_1000, 32'h0, "meip_clr");

    // Arbitration between sources 2 and 6
    extintsrc_req[2] = 1'b1;
    extintsrc_req[6] = 1'b1;
    wr(32'h0000_2018, 32'h0000_0001);
    wr(32'h0000_0008, 32'h0000_0007);
    wr(32'h0000_0018, 32'h0000_0007);
    tick();
    tick();
    check_claim("tie", 8'd2, 4'd7, 1'b1);
    wr(32'h0000_0018, 32'h0000_0009);
    check_claim("raise_lat", 8'd2, 4'd7, 1'b1);
    tick();
    check_claim("raise", 8'd6, 4'd9, 1'b1);
    extintsrc_req[2] = 1'b0;
    extintsrc_req[6] = 1'b0;
    tick();
    tick();
    tick();
    check_claim("drop", 8'd0, 4'd0, 1'b0);

    // Active-low level source 4
    wr(32'h0000_2010, 32'h0000_0001);
    wr(32'h0000_0010, 32'h0000_0001);
    wr(32'h0000_4010, 32'h0000_0001);
    tick();
    check_claim("pol_lat", 8'd0, 4'd0, 1'b0);
    tick();
    check_claim("pol", 8'd4, 4'd1, 1'b1);
    wr(32'h0000_0010, 32'h0);
    tick();
    check_claim("pl_zero", 8'd0, 4'd0, 1'b0);

    // Reset during a read with a claim active
    wr(32'h0000_0010, 32'h0000_0003);
    tick();
    check_claim("pre_reset", 8'd4, 4'd3, 1'b1);
    rst_l        = 1'b0;
    picm_rden    = 1'b1;
    picm_addr    = 32'h0000_2008;
    tick();
    picm_rden    = 1'b0;
    rst_l        = 1'b1;
    check("rst_rd_data", picm_rd_data, 32'h0);
    check_claim("rst", 8'd0, 4'd0, 1'b0);
    rd(32'h0000_2008, 32'h0, "rd_meie2_after_rst");
    rd(32'h0000_000C, 32'h0, "rd_meipl3_after_rst");
    tick();
    check_claim("post_rst", 8'd0, 4'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
